// File: rtl/gb_video_pkg.sv
// Shared constants and types for the Game Boy LCD capture path.
// Frame geometry is fixed to the DMG panel; all byte addressing derives from it.
package gb_video_pkg;

  localparam int H_PIXELS       = 160;
  localparam int V_LINES        = 144;
  localparam int FRAME_PIXELS   = H_PIXELS * V_LINES;
  localparam int BYTES_PER_BANK = FRAME_PIXELS / 4;
  localparam int ADDR_W         = 14;
  localparam int CNT_W          = 15;

  typedef logic [1:0] shade_t;

  typedef enum logic {
    WAIT_SYNC,
    CAPTURE
  } cap_state_t;

  // Byte address inside the double-buffered store: bank 1 sits right above bank 0.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [12:0] offset);
    return (bank ? ADDR_W'(BYTES_PER_BANK) : '0) + {1'b0, offset};
  endfunction

endpackage

// File: rtl/gb_lcd_capture_if.sv
// PPU pixel stream plus the random-access read port of the frame store.
// The master drives pixels and read requests; the capture block is the slave.
interface gb_lcd_capture_if;
  import gb_video_pkg::*;

  shade_t     LD;
  logic       PX_VALID;
  logic       S;
  logic [7:0] rd_x;
  logic [7:0] rd_y;
  logic       rd_req;
  shade_t     rd_px;
  logic       rd_valid;

  modport master (
    output LD, PX_VALID, S, rd_x, rd_y, rd_req,
    input  rd_px, rd_valid
  );

  modport slave (
    input  LD, PX_VALID, S, rd_x, rd_y, rd_req,
    output rd_px, rd_valid
  );

endinterface

// File: rtl/gb_fb_dpram.sv
// Simple dual-port 8x11520 frame store holding both banks.
// Read address and read data are both registered, so a read costs two clocks.
module gb_fb_dpram
  import gb_video_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 2 * BYTES_PER_BANK;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] raddr_q;
  logic [7:0]        rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    raddr_q <= raddr;
    rdata_q <= mem[raddr_q];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gb_lcd_capture.sv
// Packs the PPU pixel stream into a double-buffered frame store and serves
// pixel reads from the bank holding the last complete frame.
module gb_lcd_capture
  import gb_video_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  gb_lcd_capture_if.slave   bus,
  output logic              frame_done,
  output logic              disp_bank,
  output logic              overrun,
  output logic              sync_err
);

  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       pack_q, pack_d;
  logic             wr_bank_q, wr_bank_d;
  logic             disp_bank_q, disp_bank_d;
  logic             done_q, done_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;
  logic             sync_err_q, sync_err_d;

  logic             last_px;
  logic [7:0]       px_byte;
  logic             we;
  logic [ADDR_W-1:0] waddr;

  logic [CNT_W-1:0] rd_lin;
  logic             rd_oob;
  logic [ADDR_W-1:0] raddr;
  logic [7:0]       rdata;

  logic             req1_q, req1_d, req2_q, req2_d;
  logic             oob1_q, oob1_d, oob2_q, oob2_d;
  logic [1:0]       sel1_q, sel1_d, sel2_q, sel2_d;
  logic             rd_valid_q, rd_valid_d;
  shade_t           rd_px_q, rd_px_d;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pack_d       = pack_q;
    wr_bank_d    = wr_bank_q;
    disp_bank_d  = disp_bank_q;
    done_d       = done_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    sync_err_d   = 1'b0;
    we           = 1'b0;
    last_px      = (count_q == CNT_W'(FRAME_PIXELS - 1));
    px_byte      = pack_q;
    px_byte[{count_q[1:0], 1'b0} +: 2] = bus.LD;
    waddr        = bank_addr(wr_bank_q, count_q[14:2]);

    unique case (state_q)
      WAIT_SYNC: begin
        if (bus.S) begin
          state_d   = CAPTURE;
          count_d   = '0;
          pack_d    = '0;
          overrun_d = 1'b0;
          done_d    = 1'b0;
        end else if (bus.PX_VALID && done_q) begin
          overrun_d = 1'b1;
        end
      end
      CAPTURE: begin
        // A sync on the final pixel still completes the frame; any other sync restarts it.
        if (bus.S && !(bus.PX_VALID && last_px)) begin
          count_d    = '0;
          pack_d     = '0;
          overrun_d  = 1'b0;
          sync_err_d = (count_q != '0);
        end else if (bus.PX_VALID) begin
          pack_d = px_byte;
          we     = (count_q[1:0] == 2'd3);
          if (last_px) begin
            count_d      = '0;
            pack_d       = '0;
            wr_bank_d    = ~wr_bank_q;
            disp_bank_d  = wr_bank_q;
            frame_done_d = 1'b1;
            if (bus.S) begin
              overrun_d = 1'b0;
            end else begin
              state_d = WAIT_SYNC;
              done_d  = 1'b1;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  // Bank is chosen at request time so a swap in flight cannot tear a read.
  always_comb begin
    rd_lin     = ({7'd0, bus.rd_y} << 7) + ({7'd0, bus.rd_y} << 5) + {7'd0, bus.rd_x};
    rd_oob     = (bus.rd_x >= 8'(H_PIXELS)) || (bus.rd_y >= 8'(V_LINES));
    raddr      = rd_oob ? '0 : bank_addr(disp_bank_q, rd_lin[14:2]);
    req1_d     = bus.rd_req;
    oob1_d     = rd_oob;
    sel1_d     = rd_lin[1:0];
    req2_d     = req1_q;
    oob2_d     = oob1_q;
    sel2_d     = sel1_q;
    rd_valid_d = req2_q;
    rd_px_d    = '0;
    if (req2_q && !oob2_q) begin
      rd_px_d = rdata[{sel2_q, 1'b0} +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= WAIT_SYNC;
      count_q      <= '0;
      pack_q       <= '0;
      wr_bank_q    <= 1'b0;
      disp_bank_q  <= 1'b1;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
      req1_q       <= 1'b0;
      oob1_q       <= 1'b0;
      sel1_q       <= '0;
      req2_q       <= 1'b0;
      oob2_q       <= 1'b0;
      sel2_q       <= '0;
      rd_valid_q   <= 1'b0;
      rd_px_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pack_q       <= pack_d;
      wr_bank_q    <= wr_bank_d;
      disp_bank_q  <= disp_bank_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
      req1_q       <= req1_d;
      oob1_q       <= oob1_d;
      sel1_q       <= sel1_d;
      req2_q       <= req2_d;
      oob2_q       <= oob2_d;
      sel2_q       <= sel2_d;
      rd_valid_q   <= rd_valid_d;
      rd_px_q      <= rd_px_d;
    end
  end

  gb_fb_dpram u_fb_dpram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (px_byte),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign bus.rd_px    = rd_px_q;
  assign bus.rd_valid = rd_valid_q;
  assign frame_done   = frame_done_q;
  assign disp_bank    = disp_bank_q;
  assign overrun      = overrun_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: frames, aborts, overrun, coincident sync,
// mid-frame reset; pixel reads are checked through an expected-value queue.
module tb_gb_lcd_capture;

  logic clk;
  logic rst;
  logic frame_done;
  logic disp_bank;
  logic overrun;
  logic sync_err;

  gb_lcd_capture_if bus ();

  gb_lcd_capture dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .disp_bank  (disp_bank),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  typedef struct {
    logic [1:0] px;
    int         due;
  } rd_exp_t;

  rd_exp_t sb[$];
  int      errors = 0;
  int      checks = 0;
  int      cyc    = 0;
  int      fd_cnt = 0;
  int      se_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Pulse counters and scoreboard pop, sampled away from the active edge.
  always @(negedge clk) begin
    rd_exp_t e;
    if (frame_done === 1'b1) fd_cnt++;
    if (sync_err === 1'b1) se_cnt++;
    if (bus.rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("rd_unexpected_valid", {31'd0, bus.rd_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("rd_px", {30'd0, bus.rd_px}, {30'd0, e.px});
        check_output("rd_latency", cyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      check_output("rd_timeout", {31'd0, bus.rd_valid}, 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixels(input int n, input bit pattern, input logic [1:0] shade);
    for (int i = 0; i < n; i++) begin
      bus.PX_VALID = 1'b1;
      bus.LD       = pattern ? 2'(i % 4) : shade;
      bus.S        = 1'b0;
      idle(1);
    end
    bus.PX_VALID = 1'b0;
  endtask

  task automatic pulse_s(input bit with_px);
    bus.S        = 1'b1;
    bus.PX_VALID = with_px;
    bus.LD       = 2'd3;
    idle(1);
    bus.S        = 1'b0;
    bus.PX_VALID = 1'b0;
  endtask

  task automatic issue_read(input logic [7:0] x, input logic [7:0] y, input logic [1:0] expv);
    bus.rd_x   = x;
    bus.rd_y   = y;
    bus.rd_req = 1'b1;
    sb.push_back('{px: expv, due: cyc + 3});
    idle(1);
    bus.rd_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
    check_output("rd_drain", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus.LD = '0; bus.PX_VALID = 1'b0; bus.S = 1'b0;
    bus.rd_x = '0; bus.rd_y = '0; bus.rd_req = 1'b0;
    idle(3);
    check_output("rst_rd_px", {30'd0, bus.rd_px}, 32'd0);
    check_output("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check_output("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_output("rst_overrun", {31'd0, overrun}, 32'd0);
    check_output("rst_sync_err", {31'd0, sync_err}, 32'd0);
    check_output("rst_disp_bank", {31'd0, disp_bank}, 32'd1);
    rst = 1'b1;
    idle(2);

    $display("[TB] frame 1: shade = count %% 4, S carries a dropped pixel");
    pulse_s(1'b1);
    send_pixels(23040, 1'b1, 2'd0);
    idle(3);
    check_output("f1_frame_done_cnt", fd_cnt, 32'd1);
    check_output("f1_disp_bank", {31'd0, disp_bank}, 32'd0);
    check_output("f1_sync_err_cnt", se_cnt, 32'd0);
    issue_read(8'd5, 8'd0, 2'd1);
    issue_read(8'd159, 8'd143, 2'd3);
    issue_read(8'd0, 8'd0, 2'd0);
    issue_read(8'd2, 8'd1, 2'd2);
    issue_read(8'd160, 8'd0, 2'd0);
    issue_read(8'd3, 8'd144, 2'd0);
    drain();

    $display("[TB] overrun: 5 pixels after completion without S");
    check_output("ovr_before", {31'd0, overrun}, 32'd0);
    send_pixels(5, 1'b0, 2'd0);
    idle(1);
    check_output("ovr_set", {31'd0, overrun}, 32'd1);
    idle(3);
    check_output("ovr_sticky", {31'd0, overrun}, 32'd1);
    check_output("ovr_no_frame_done", fd_cnt, 32'd1);
    issue_read(8'd5, 8'd0, 2'd1);
    issue_read(8'd1, 8'd0, 2'd1);
    drain();
    pulse_s(1'b0);
    check_output("ovr_cleared_by_s", {31'd0, overrun}, 32'd0);

    $display("[TB] abort: S after 1000 pixels");
    send_pixels(1000, 1'b0, 2'd3);
    pulse_s(1'b0);
    idle(2);
    check_output("abort_sync_err_cnt", se_cnt, 32'd1);
    check_output("abort_no_frame_done", fd_cnt, 32'd1);
    check_output("abort_disp_bank", {31'd0, disp_bank}, 32'd0);

    $display("[TB] frame 2: shade 2, S on the final pixel, read straddling the swap");
    send_pixels(23039, 1'b0, 2'd2);
    bus.PX_VALID = 1'b1; bus.LD = 2'd2; bus.S = 1'b1;
    issue_read(8'd5, 8'd0, 2'd1);
    bus.PX_VALID = 1'b0; bus.S = 1'b0;
    idle(2);
    check_output("f2_frame_done_cnt", fd_cnt, 32'd2);
    check_output("f2_no_sync_err", se_cnt, 32'd1);
    check_output("f2_disp_bank", {31'd0, disp_bank}, 32'd1);
    issue_read(8'd7, 8'd9, 2'd2);
    issue_read(8'd159, 8'd143, 2'd2);
    drain();

    $display("[TB] frame 3: shade 1, no S needed after coincident sync");
    send_pixels(23040, 1'b0, 2'd1);
    idle(2);
    check_output("f3_frame_done_cnt", fd_cnt, 32'd3);
    check_output("f3_disp_bank", {31'd0, disp_bank}, 32'd0);
    check_output("f3_sync_err_cnt", se_cnt, 32'd1);
    issue_read(8'd0, 8'd0, 2'd1);
    issue_read(8'd80, 8'd72, 2'd1);
    issue_read(8'd159, 8'd143, 2'd1);
    drain();

    $display("[TB] reset at pixel 12000 of a new frame");
    pulse_s(1'b0);
    send_pixels(12000, 1'b0, 2'd3);
    bus.PX_VALID = 1'b1; bus.LD = 2'd3;
    rst = 1'b0;
    idle(2);
    check_output("mrst_rd_px", {30'd0, bus.rd_px}, 32'd0);
    check_output("mrst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check_output("mrst_frame_done", {31'd0, frame_done}, 32'd0);
    check_output("mrst_overrun", {31'd0, overrun}, 32'd0);
    check_output("mrst_sync_err", {31'd0, sync_err}, 32'd0);
    check_output("mrst_disp_bank", {31'd0, disp_bank}, 32'd1);
    rst = 1'b1;
    send_pixels(100, 1'b0, 2'd0);
    idle(2);
    check_output("mrst_ignored_no_fd", fd_cnt, 32'd3);
    check_output("mrst_ignored_no_ovr", {31'd0, overrun}, 32'd0);
    issue_read(8'd200, 8'd0, 2'd0);
    issue_read(8'd159, 8'd143, 2'd2);
    issue_read(8'd0, 8'd0, 2'd3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
